// File: rtl/qtable_updater.sv
// qtable_updater: one Q-learning read-modify-write per start on the Q-table RAM
module qtable_updater #(
  parameter int WORD_WIDTH  = 16,
  parameter int MEM_DEPTH   = 1024,
  parameter int ALPHA_SHIFT = 2,
  parameter int GAMMA_SHIFT = 1,
  parameter int INVALID_HOP = 100
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] _neighborID,
  input  logic [WORD_WIDTH-1:0] _reward,
  input  logic [WORD_WIDTH-1:0] _bestvalue,
  output logic [WORD_WIDTH-1:0] address,
  output logic                  mem_rd,
  input  logic [WORD_WIDTH-1:0] data_in,
  output logic [WORD_WIDTH-1:0] data_out,
  output logic                  mem_we,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [WORD_WIDTH-1:0] lasthop,
  output logic [WORD_WIDTH-1:0] q_new
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, CALC, WRITE, DONE} state_t;
  state_t state;
  logic [WORD_WIDTH-1:0] id, reward, best, q_old, target, result;
  logic [WORD_WIDTH:0] target_raw;
  logic bad, req_bad;
  assign req_bad = (_neighborID == WORD_WIDTH'(INVALID_HOP)) || (32'(_neighborID) >= MEM_DEPTH);
  assign target_raw = {1'b0, reward} + {1'b0, best >> GAMMA_SHIFT};
  assign target = target_raw[WORD_WIDTH] ? '1 : target_raw[WORD_WIDTH-1:0];
  // Branch on sign so the shifted difference never wraps
  assign result = (target >= q_old) ? q_old + ((target - q_old) >> ALPHA_SHIFT)
                                    : q_old - ((q_old - target) >> ALPHA_SHIFT);
  assign busy = state != IDLE;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      id       <= '0;
      reward   <= '0;
      best     <= '0;
      q_old    <= '0;
      bad      <= 1'b0;
      address  <= '0;
      data_out <= '0;
      q_new    <= '0;
      lasthop  <= WORD_WIDTH'(INVALID_HOP);
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          id     <= _neighborID;
          reward <= _reward;
          best   <= _bestvalue;
          bad    <= req_bad;
          mem_rd <= !req_bad;
          if (!req_bad) address <= _neighborID;
          state  <= READ;
        end
        READ: begin
          mem_rd <= 1'b0;
          done   <= bad;
          error  <= bad ? 1'b1 : error;
          state  <= bad ? DONE : WAIT;
        end
        WAIT: begin
          q_old <= data_in;
          state <= CALC;
        end
        CALC: begin
          data_out <= result;
          mem_we   <= 1'b1;
          state    <= WRITE;
        end
        WRITE: begin
          mem_we  <= 1'b0;
          q_new   <= data_out;
          lasthop <= id;
          done    <= 1'b1;
          error   <= 1'b0;
          state   <= DONE;
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
